// File: rtl/coin_pkg.sv
// Coin codes and debouncer state encoding, shared with the vending controller.
package coin_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_5    = 2'b01;
    localparam coin_t COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        DB_LOW       = 2'd0,
        DB_RISE_WAIT = 2'd1,
        DB_HIGH      = 2'd2,
        DB_FALL_WAIT = 2'd3
    } db_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchronizer, level debouncer and a single detect
// pulse per accepted rising edge.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_raw,
    output logic o_detect
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1, r_sync2;
    db_state_e       r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            w_detect;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= DB_LOW;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Detect is decoded from the transition so the push lands on the same edge
    // the debouncer enters HIGH.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_detect    = 1'b0;
        case (r_state)
            DB_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = DB_RISE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            DB_RISE_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = DB_LOW;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = DB_HIGH;
                    w_cnt_nxt   = '0;
                    w_detect    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DB_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = DB_FALL_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            DB_FALL_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = DB_HIGH;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = DB_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = DB_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_detect = w_detect;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounces nickel/dime sensors, queues coins in a FIFO with
// registered outputs, and fires the reject solenoid. Optional COIN_AUDIT_EN
// adds audit_total / audit_rejects counters.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             nickel_in,
    input  logic                             dime_in,
    input  logic                             coin_ready,
    output logic [1:0]                       coin,
    output logic                             coin_valid,
    output logic                             reject_pulse,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_level
`ifdef COIN_AUDIT_EN
    ,
    output logic [15:0]                      audit_total,
    output logic [7:0]                       audit_rejects
`endif
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int LW = $clog2(QUEUE_DEPTH + 1);

    logic          w_nk_det, w_dm_det;
    logic          w_push_req, w_push, w_pop, w_drop, w_reject;
    coin_t         w_push_code, w_head_nxt;
    logic [LW-1:0] w_level_nxt;
    logic [AW-1:0] w_rd_nxt;

    coin_t         r_mem [QUEUE_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [LW-1:0] r_level;
    coin_t         r_coin;
    logic          r_valid;
    logic          r_reject;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nickel (
        .clk      (clk),
        .rstn     (rstn),
        .i_raw    (nickel_in),
        .o_detect (w_nk_det)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dime (
        .clk      (clk),
        .rstn     (rstn),
        .i_raw    (dime_in),
        .o_detect (w_dm_det)
    );

    always_comb begin
        w_push_req  = w_nk_det ^ w_dm_det;
        w_push_code = w_nk_det ? COIN_5 : COIN_10;
        w_pop       = r_valid & coin_ready;
        w_push      = w_push_req & ((r_level < LW'(QUEUE_DEPTH)) | w_pop);
        w_drop      = w_push_req & ~w_push;
        w_reject    = (w_nk_det & w_dm_det) | w_drop;
        w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
        w_rd_nxt    = r_rd + AW'(w_pop);
        // Next head: the incoming coin if the queue drains to empty this cycle.
        if (w_level_nxt == '0)
            w_head_nxt = COIN_NONE;
        else if (r_level == LW'(w_pop))
            w_head_nxt = w_push_code;
        else
            w_head_nxt = r_mem[w_rd_nxt];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) r_mem[i] <= COIN_NONE;
            r_wr     <= '0;
            r_rd     <= '0;
            r_level  <= '0;
            r_coin   <= COIN_NONE;
            r_valid  <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_push_code;
                r_wr        <= r_wr + 1'b1;
            end
            r_rd     <= w_rd_nxt;
            r_level  <= w_level_nxt;
            r_coin   <= w_head_nxt;
            r_valid  <= (w_level_nxt != '0);
            r_reject <= w_reject;
        end
    end

    assign coin         = r_coin;
    assign coin_valid   = r_valid;
    assign reject_pulse = r_reject;
    assign queue_level  = r_level;

`ifdef COIN_AUDIT_EN
    logic [15:0] r_audit_total;
    logic [7:0]  r_audit_rejects;
    logic [16:0] w_audit_sum;

    assign w_audit_sum = {1'b0, r_audit_total} + ((r_coin == COIN_10) ? 17'd10 : 17'd5);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_audit_total   <= '0;
            r_audit_rejects <= '0;
        end else begin
            if (w_pop)
                r_audit_total <= w_audit_sum[16] ? 16'hFFFF : w_audit_sum[15:0];
            if (w_reject && r_audit_rejects != 8'hFF)
                r_audit_rejects <= r_audit_rejects + 1'b1;
        end
    end

    assign audit_total   = r_audit_total;
    assign audit_rejects = r_audit_rejects;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=4).
module tb_coin_acceptor;

    localparam int DB = 4;
    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       rstn, nickel_in, dime_in, coin_ready;
    logic [1:0] coin;
    logic       coin_valid, reject_pulse;
    logic [2:0] queue_level;
`ifdef COIN_AUDIT_EN
    logic [15:0] audit_total;
    logic [7:0]  audit_rejects;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int pops   = 0;
    int rejs   = 0;
    logic [1:0] popq[$];

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(QD)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .nickel_in    (nickel_in),
        .dime_in      (dime_in),
        .coin_ready   (coin_ready),
        .coin         (coin),
        .coin_valid   (coin_valid),
        .reject_pulse (reject_pulse),
        .queue_level  (queue_level)
`ifdef COIN_AUDIT_EN
        ,
        .audit_total  (audit_total),
        .audit_rejects(audit_rejects)
`endif
    );

    // Pops and reject pulses observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rstn && coin_valid && coin_ready) begin
            pops++;
            popq.push_back(coin);
        end
        if (reject_pulse) rejs++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic coin_in(input bit is_dime, input int hi, input int lo);
        if (is_dime) dime_in = 1'b1; else nickel_in = 1'b1;
        tick(hi);
        dime_in   = 1'b0;
        nickel_in = 1'b0;
        tick(lo);
    endtask

    int n, p0, r0;

    initial begin
        rstn = 1'b0; nickel_in = 1'b0; dime_in = 1'b0; coin_ready = 1'b1;
        tick(3);
        chk("rst_valid", coin_valid, 0);
        chk("rst_coin", coin, 0);
        chk("rst_reject", reject_pulse, 0);
        chk("rst_level", queue_level, 0);
        rstn = 1'b1;
        tick(3);

        // 1: single nickel, latency and immediate pop
        nickel_in = 1'b1;
        n = 0;
        while (!coin_valid && n < 40) begin tick(); n++; end
        chk("t1_latency", n, 7);
        chk("t1_coin", coin, 1);
        tick();
        chk("t1_valid_drop", coin_valid, 0);
        chk("t1_level", queue_level, 0);
        tick(2);
        nickel_in = 1'b0;
        tick(12);
        chk("t1_pops", pops, 1);
        chk("t1_rejs", rejs, 0);

        // 2: glitch ignored, then a real dime
        coin_in(1, 3, 20);
        chk("t2_glitch_pops", pops, 1);
        chk("t2_glitch_rejs", rejs, 0);
        coin_in(1, 6, 12);
        chk("t2_pops", pops, 2);
        chk("t2_code", popq[popq.size()-1], 2);

        // 3: simultaneous detection rejects
        nickel_in = 1'b1; dime_in = 1'b1;
        tick(8);
        nickel_in = 1'b0; dime_in = 1'b0;
        tick(12);
        chk("t3_rejs", rejs, 1);
        chk("t3_pops", pops, 2);
        chk("t3_level", queue_level, 0);

        // 4: fill under stall, overflow, drain in order
        coin_ready = 1'b0;
        popq.delete();
        coin_in(0, 6, 10);
        chk("t4_head1", coin, 1);
        coin_in(1, 6, 10);
        coin_in(1, 6, 10);
        chk("t4_stall_coin", coin, 1);
        chk("t4_stall_valid", coin_valid, 1);
        coin_in(0, 6, 10);
        chk("t4_level_full", queue_level, 4);
        coin_in(1, 6, 10);
        chk("t4_overflow_rej", rejs, 2);
        chk("t4_level_after_ovf", queue_level, 4);
        chk("t4_head_after_ovf", coin, 1);
        coin_ready = 1'b1;
        tick(4);
        coin_ready = 1'b0;
        tick();
        chk("t4_npop", popq.size(), 4);
        chk("t4_pop0", popq[0], 1);
        chk("t4_pop1", popq[1], 2);
        chk("t4_pop2", popq[2], 2);
        chk("t4_pop3", popq[3], 1);
        chk("t4_level_empty", queue_level, 0);
`ifdef COIN_AUDIT_EN
        chk("t4_audit_total", audit_total, 45);
        chk("t4_audit_rejects", audit_rejects, 2);
`endif

        // 5: full queue, pop and push on the same edge
        coin_in(0, 6, 10);
        coin_in(1, 6, 10);
        coin_in(0, 6, 10);
        coin_in(1, 6, 10);
        chk("t5_level_full", queue_level, 4);
        p0 = pops; r0 = rejs;
        dime_in = 1'b1;
        tick(6);
        coin_ready = 1'b1;
        tick();
        coin_ready = 1'b0;
        chk("t5_level", queue_level, 4);
        chk("t5_pop", pops, p0 + 1);
        dime_in = 1'b0;
        tick(10);
        chk("t5_no_rej", rejs, r0);
        chk("t5_level_hold", queue_level, 4);
        chk("t5_head", coin, 2);

        // 6: async reset mid-operation, held nickel re-detected once
        coin_ready = 1'b1;
        tick();
        coin_ready = 1'b0;
        chk("t6_level3", queue_level, 3);
        nickel_in = 1'b1;
        tick(2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_valid", coin_valid, 0);
        chk("t6_async_coin", coin, 0);
        chk("t6_async_level", queue_level, 0);
        chk("t6_async_reject", reject_pulse, 0);
`ifdef COIN_AUDIT_EN
        chk("t6_audit_clr", audit_total, 0);
`endif
        tick();
        rstn = 1'b1;
        n = 0;
        while (!coin_valid && n < 40) begin tick(); n++; end
        chk("t6_redetect_seen", coin_valid, 1);
        chk("t6_redetect_coin", coin, 1);
        tick(20);
        chk("t6_once", queue_level, 1);
        nickel_in = 1'b0;
        tick(12);
        chk("t6_once_after_fall", queue_level, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
